// File: rtl/inv_mixcol_seq_pkg.sv
// Shared AES definitions for the InvMixColumns engine: field polynomial,
// xtime helper and FSM state type.
package inv_mixcol_seq_pkg;

   localparam logic [7:0] AES_POLY = 8'h1B;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   function automatic logic [7:0] xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? AES_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/inv_mixcol_seq_col_inv_mix.sv
// Combinational InvMixColumns on one 32-bit column (row0 in [31:24]),
// built from xtime chains only.
module col_inv_mix
   import inv_mixcol_seq_pkg::*;
(
   input  logic [31:0] col_in,
   output logic [31:0] col_out
);

   logic [7:0] s  [4];
   logic [7:0] x2 [4];
   logic [7:0] x4 [4];
   logic [7:0] x8 [4];
   logic [7:0] m9 [4];
   logic [7:0] mb [4];
   logic [7:0] md [4];
   logic [7:0] me [4];

   for (genvar r = 0; r < 4; r++) begin : g_row
      assign s[r]  = col_in[31-8*r -: 8];
      assign x2[r] = xtime(s[r]);
      assign x4[r] = xtime(x2[r]);
      assign x8[r] = xtime(x4[r]);
      assign m9[r] = x8[r] ^ s[r];
      assign mb[r] = x8[r] ^ x2[r] ^ s[r];
      assign md[r] = x8[r] ^ x4[r] ^ s[r];
      assign me[r] = x8[r] ^ x4[r] ^ x2[r];
   end

   // Row r uses the circulant {0e,0b,0d,09} rotated right by r.
   for (genvar r = 0; r < 4; r++) begin : g_out
      assign col_out[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
   end

endmodule

// File: rtl/inv_mixcol_seq.sv
// Sequential InvMixColumns engine: transforms a 128-bit AES state
// COLS_PER_CYCLE columns per clock, with valid/ready on both sides.
module inv_mixcol_seq
   import inv_mixcol_seq_pkg::*;
#(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_in,
   input  logic         kill,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out
);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
      $error("inv_mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE % 4);
   localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

   state_t       state, state_nxt;
   logic [1:0]   col, col_nxt;
   logic [127:0] st_reg, st_nxt;

   logic [31:0]  cols     [4];
   logic [31:0]  cols_nxt [4];
   logic [31:0]  mix_out  [4];
   logic [127:0] mixed;

   for (genvar j = 0; j < 4; j++) begin : g_col
      assign cols[j] = st_reg[127-32*j -: 32];
   end

   for (genvar k = 0; k < 4; k++) begin : g_lane
      if (k < COLS_PER_CYCLE) begin : g_on
         col_inv_mix u_mix (
            .col_in  (cols[col + 2'(k)]),
            .col_out (mix_out[k])
         );
      end else begin : g_off
         assign mix_out[k] = '0;
      end
   end

   // Column j belongs to lane (j - col) mod 4 this cycle; lanes >= COLS_PER_CYCLE keep it.
   for (genvar j = 0; j < 4; j++) begin : g_merge
      logic [1:0] off;
      assign off         = 2'(j) - col;
      assign cols_nxt[j] = ({1'b0, off} < 3'(COLS_PER_CYCLE)) ? mix_out[off] : cols[j];
   end

   assign mixed    = {cols_nxt[0], cols_nxt[1], cols_nxt[2], cols_nxt[3]};
   assign data_out = st_reg;

   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      st_nxt    = st_reg;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid && !kill) begin
               st_nxt    = data_in;
               col_nxt   = '0;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            st_nxt  = mixed;
            col_nxt = col + COL_STEP;
            if (col == LAST_COL) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (kill) begin
         state_nxt = IDLE;
         col_nxt   = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         col    <= '0;
         st_reg <= '0;
      end else begin
         state  <= state_nxt;
         col    <= col_nxt;
         st_reg <= st_nxt;
      end
   end

endmodule

// File: tb/tb_inv_mixcol_seq.sv
// Self-checking bench for inv_mixcol_seq: one instance per legal
// COLS_PER_CYCLE, checked against a GF(2^8) matrix reference model.
module tb_inv_mixcol_seq;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic [127:0] data_in   [3];
   logic         kill      [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [127:0] data_out  [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      inv_mixcol_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
         .clk       (clk),
         .reset     (reset),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .data_in   (data_in[g]),
         .kill      (kill[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .data_out  (data_out[g])
      );
   end

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Generic shift-and-add GF(2^8) multiply.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int n = 0; n < 8; n++) begin
         if (b[n]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [127:0] ref_imix(input logic [127:0] st);
      logic [7:0]   base [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      logic [127:0] res = '0;
      logic [7:0]   a [4];
      logic [7:0]   acc;
      for (int j = 0; j < 4; j++) begin
         for (int r = 0; r < 4; r++) a[r] = st[127-32*j-8*r -: 8];
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int c = 0; c < 4; c++) acc ^= gmul(base[(c - r + 4) % 4], a[c]);
            res[127-32*j-8*r -: 8] = acc;
         end
      end
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(input int i, output int lat);
      lat = 0;
      while (!out_valid[i] && lat < 16) begin
         tick();
         lat++;
      end
   endtask

   task automatic xfer(input int i, input logic [127:0] din, input logic [127:0] exp,
                       input int hold, input string tag);
      int lat;
      check_val({tag, "_in_ready"}, 128'(in_ready[i]), 128'(1));
      in_valid[i] = 1'b1;
      data_in[i]  = din;
      tick();
      in_valid[i] = 1'b0;
      data_in[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
      wait_out(i, lat);
      check_val({tag, "_latency"}, 128'(lat), 128'(4 >> i));
      check_val({tag, "_data"}, data_out[i], exp);
      for (int h = 0; h < hold; h++) begin
         tick();
         check_val({tag, "_hold"}, {data_out[i][126:0], out_valid[i]}, {exp[126:0], 1'b1});
      end
      out_ready[i] = 1'b1;
      tick();
      out_ready[i] = 1'b0;
      check_val({tag, "_after_hs"}, {126'(0), out_valid[i], in_ready[i]}, 128'(1));
   endtask

   localparam logic [127:0] V_IN  = 128'h9fdc589d_4d7ebdf8_8e4da1bc_d5d5d7d6;
   localparam logic [127:0] V_OUT = 128'hf20a225c_2d26314c_db135345_d4d4d4d5;
   localparam logic [127:0] V_INV = 128'h01010101_c6c6c6c6_00000000_ffffffff;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [127:0] a, b;
      int           lat;
      logic         seen;

      for (int i = 0; i < 3; i++) begin
         in_valid[i]  = 1'b0;
         data_in[i]   = '0;
         kill[i]      = 1'b0;
         out_ready[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check_val("reset_state", {data_out[i], in_ready[i], out_valid[i]}, {128'(0), 2'b10});
      end
      @(negedge clk);
      reset = 1'b1;
      tick();

      // Known-answer vectors
      xfer(0, 128'h8e4da1bc_00000000_00000000_00000000,
              128'hdb135345_00000000_00000000_00000000, 0, "fips_col");
      for (int i = 0; i < 3; i++) xfer(i, V_IN, V_OUT, 1, "full_state");
      xfer(0, V_INV, V_INV, 0, "invariant");

      // Backpressure with the next input already waiting
      a = {$urandom(), $urandom(), $urandom(), $urandom()};
      b = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_valid[0] = 1'b1;
      data_in[0]  = a;
      tick();
      data_in[0]  = b;
      wait_out(0, lat);
      check_val("bp_latency", 128'(lat), 128'(4));
      for (int h = 0; h < 10; h++) begin
         check_val("bp_stall", {data_out[0][126:0], in_ready[0]}, {ref_imix(a)[126:0], 1'b0});
         tick();
      end
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;
      check_val("bp_idle", {126'(0), in_ready[0], out_valid[0]}, 128'(2));
      tick();
      check_val("bp_accept", 128'(in_ready[0]), 128'(0));
      in_valid[0] = 1'b0;
      wait_out(0, lat);
      check_val("bp_second", data_out[0], ref_imix(b));
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;

      // kill on the second BUSY edge, then kill+in_valid while idle
      in_valid[0] = 1'b1;
      data_in[0]  = a;
      tick();
      tick();
      kill[0] = 1'b1;
      tick();
      check_val("kill_idle", {126'(0), in_ready[0], out_valid[0]}, 128'(2));
      tick();
      check_val("kill_no_accept", 128'(in_ready[0]), 128'(1));
      kill[0]     = 1'b0;
      in_valid[0] = 1'b0;
      seen = 1'b0;
      for (int h = 0; h < 6; h++) begin
         tick();
         seen |= out_valid[0];
      end
      check_val("kill_no_out", 128'(seen), 128'(0));
      xfer(0, b, ref_imix(b), 0, "post_kill");

      // Asynchronous reset in the middle of BUSY
      in_valid[0] = 1'b1;
      data_in[0]  = a;
      tick();
      in_valid[0] = 1'b0;
      tick();
      #2;
      reset = 1'b0;
      #1;
      check_val("async_reset", {data_out[0], in_ready[0], out_valid[0]}, {128'(0), 2'b10});
      @(negedge clk);
      reset = 1'b1;
      tick();
      xfer(0, b, ref_imix(b), 0, "post_reset");

      // Randomized traffic across all three widths
      for (int n = 0; n < 30; n++) begin
         int i;
         i = int'($urandom_range(0, 2));
         a = {$urandom(), $urandom(), $urandom(), $urandom()};
         xfer(i, a, ref_imix(a), int'($urandom_range(0, 3)), "random");
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
